updown_ctrl: RTL and testbench

Front-panel control stage that sits directly upstream of the 4-bit up/down counter and drives its `updown` and `clear` inputs. It synchronises and debounces three raw push-buttons (up, down, clear), holds a registered count direction, and issues a single-cycle clear pulse per debounced clear press. Each button press yields exactly one event, however long it bounces or is held.

---
 rtl/updown_ctrl.sv | 89 ++++++++
 tb/tb_updown_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/updown_ctrl.sv
// Front-panel control for the 4-bit up/down counter: synchronises and debounces
// three push-buttons, holds the count direction and issues one-cycle clear pulses.
module updown_ctrl #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic clear,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_clr,
   output logic updown,
   output logic clr_pulse,
   output logic dir_changed
);

   localparam logic [0:0] ST_DOWN  = 1'b0;
   localparam logic [0:0] ST_UP    = 1'b1;
   localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

   localparam int B_UP  = 0;
   localparam int B_DN  = 1;
   localparam int B_CLR = 2;

   logic [2:0] btn;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] db;
   logic [2:0] db_q;
   logic [2:0] ev;
   logic [7:0] cnt [3];
   logic [0:0] state;
   logic [0:0] state_nxt;

   assign btn = {btn_clr, btn_down, btn_up};

   // Synchroniser and debouncer stage: db follows s2 only after a stable run
   always_ff @(posedge clk) begin
      if (clear) begin
         s1   <= '0;
         s2   <= '0;
         db   <= '0;
         db_q <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         db_q <= db;
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign ev = db & ~db_q;

   // Clear wins over direction; simultaneous up and down cancel each other
   always_comb begin
      state_nxt = state;
      if (!ev[B_CLR]) begin
         if (state == ST_DOWN && ev[B_UP] && !ev[B_DN])
            state_nxt = ST_UP;
         else if (state == ST_UP && ev[B_DN] && !ev[B_UP])
            state_nxt = ST_DOWN;
      end
   end

   // Output stage
   always_ff @(posedge clk) begin
      if (clear) begin
         state       <= ST_DOWN;
         clr_pulse   <= 1'b0;
         dir_changed <= 1'b0;
      end else begin
         state       <= state_nxt;
         clr_pulse   <= ev[B_CLR];
         dir_changed <= (state_nxt != state);
      end
   end

   assign updown = state[0];

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl: expected output events are queued with the
// cycle they must appear in, and every cycle the outputs are checked.
module tb_updown_ctrl;

   logic clk = 1'b0;
   logic clear = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic btn_clr = 1'b0;
   logic updown;
   logic clr_pulse;
   logic dir_changed;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   logic exp_ud = 1'b0;

   typedef struct {
      int   cyc;
      logic ud;
      logic cp;
      logic dc;
   } ev_t;

   ev_t q[$];

   updown_ctrl #(.DB_CYCLES(4)) dut (
      .clk(clk),
      .clear(clear),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_clr(btn_clr),
      .updown(updown),
      .clr_pulse(clr_pulse),
      .dir_changed(dir_changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int c, input logic ud, input logic cp, input logic dc);
      ev_t e;
      e.cyc = c;
      e.ud  = ud;
      e.cp  = cp;
      e.dc  = dc;
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard: pop the event due this cycle, otherwise expect steady outputs
   always @(negedge clk) begin
      logic e_ud, e_cp, e_dc;
      if (chk_en) begin
         e_ud = exp_ud;
         e_cp = 1'b0;
         e_dc = 1'b0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e_ud   = q[0].ud;
            e_cp   = q[0].cp;
            e_dc   = q[0].dc;
            exp_ud = q[0].ud;
            void'(q.pop_front());
         end
         chk("updown", updown, e_ud);
         chk("clr_pulse", clr_pulse, e_cp);
         chk("dir_changed", dir_changed, e_dc);
      end
   end

   initial begin
      int n;
      // reset values, then 20 idle cycles
      tick(2);
      clear  = 1'b0;
      chk_en = 1'b1;
      tick(20);

      // up press held 12 cycles: DOWN -> UP six edges after first sample
      n = cyc; btn_up = 1'b1; push(n + 7, 1'b1, 1'b0, 1'b1);
      tick(12); btn_up = 1'b0; tick(12);

      // 3-cycle glitch on down is discarded
      btn_down = 1'b1; tick(3); btn_down = 1'b0; tick(10);

      // bounce 1,0,1,1,1,1,1 then hold: one UP -> DOWN transition
      n = cyc; btn_down = 1'b1; push(n + 9, 1'b0, 1'b0, 1'b1);
      tick(1); btn_down = 1'b0;
      tick(1); btn_down = 1'b1;
      tick(8); btn_down = 1'b0; tick(12);

      // up press, then a repeat up press while UP produces nothing
      n = cyc; btn_up = 1'b1; push(n + 7, 1'b1, 1'b0, 1'b1);
      tick(8); btn_up = 1'b0; tick(12);
      btn_up = 1'b1; tick(8); btn_up = 1'b0; tick(12);

      // back to DOWN, then simultaneous up+down is ignored
      n = cyc; btn_down = 1'b1; push(n + 7, 1'b0, 1'b0, 1'b1);
      tick(8); btn_down = 1'b0; tick(12);
      btn_up = 1'b1; btn_down = 1'b1; tick(8);
      btn_up = 1'b0; btn_down = 1'b0; tick(12);

      // go UP, then clear held 10 cycles: one pulse, direction kept
      n = cyc; btn_up = 1'b1; push(n + 7, 1'b1, 1'b0, 1'b1);
      tick(8); btn_up = 1'b0; tick(12);
      n = cyc; btn_clr = 1'b1; push(n + 7, 1'b1, 1'b1, 1'b0);
      tick(10); btn_clr = 1'b0; tick(12);

      // clear and down together: clear wins, direction stays UP
      n = cyc; btn_clr = 1'b1; btn_down = 1'b1; push(n + 7, 1'b1, 1'b1, 1'b0);
      tick(8); btn_clr = 1'b0; btn_down = 1'b0; tick(12);

      // back to DOWN, then reset at edge k+3 of an up press that stays held
      n = cyc; btn_down = 1'b1; push(n + 7, 1'b0, 1'b0, 1'b1);
      tick(8); btn_down = 1'b0; tick(12);
      n = cyc; btn_up = 1'b1;
      tick(3); clear = 1'b1; push(n + 4, 1'b0, 1'b0, 1'b0);
      tick(1); clear = 1'b0;
      n = cyc; push(n + 7, 1'b1, 1'b0, 1'b1);
      tick(10); btn_up = 1'b0; tick(12);

      // reset while UP forces DOWN without a dir_changed pulse
      n = cyc; clear = 1'b1; push(n + 1, 1'b0, 1'b0, 1'b0);
      tick(2); clear = 1'b0; tick(6);

      chk_en = 1'b0;
      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("FAIL sb_drain got=%0d pending exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
